rf_write_arbiter: RTL

//  Shares the single register-file write port between the pipeline writeback stage (WB) and the multi-cycle M-extension unit (MD).
//  WB wins by default. MD results are buffered in a small FIFO and drained on cycles when WB is idle.
//  A starvation timer forces an MD drain and holds WB. Sits between the MEM/WB register, the mul/div unit and reg_file.

---
 rtl/rf_write_arbiter_pkg.sv | 20 ++
 rtl/rf_write_arbiter_fifo.sv | 113 +++++++++++
 rtl/rf_write_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// rtl/rf_write_arbiter_pkg.sv - shared state and grant encodings for the RF write arbiter
package rf_write_arbiter_pkg;

    localparam int DEF_DEPTH    = 4;
    localparam int DEF_MAX_WAIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUFFERED = 2'd1,
        ST_STARVED  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE   = 2'd0,
        GRANT_WB     = 2'd1,
        GRANT_MD     = 2'd2,
        GRANT_BYPASS = 2'd3
    } grant_t;

endpackage

// File: rtl/rf_write_arbiter_fifo.sv
// rtl/rf_write_arbiter_fifo.sv - MD result FIFO with kill-by-address and dead-entry skipping
module rf_write_arbiter_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [4:0]       i_push_addr,
    input  logic [31:0]      i_push_data,
    input  logic             i_pop_live,
    input  logic             i_kill_en,
    input  logic [4:0]       i_kill_addr,
    input  logic [4:0]       i_cmp_addr_a,
    input  logic [4:0]       i_cmp_addr_b,
    output logic             o_head_live,
    output logic [4:0]       o_head_addr,
    output logic [31:0]      o_head_data,
    output logic             o_can_push,
    output logic [CW-1:0]    o_live_after,
    output logic [DEPTH-1:0] o_match_a,
    output logic [DEPTH-1:0] o_match_b
);

    logic [DEPTH-1:0] r_valid;
    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic [PW-1:0]    w_idx;
    logic [PW-1:0]    w_head_idx;
    logic             w_found;
    logic [CW-1:0]    w_lead_dead;
    logic [CW-1:0]    w_live_cnt;
    logic [CW-1:0]    w_kill_cnt;
    logic [CW-1:0]    w_pop_live_cnt;
    logic [CW-1:0]    w_pop_cnt;

    // Walk occupied slots from the head: killed entries ahead of the first live
    // one are dropped this cycle regardless of whether the port is free.
    always_comb begin
        w_idx       = r_rd_ptr;
        w_head_idx  = r_rd_ptr;
        w_found     = 1'b0;
        w_lead_dead = '0;
        w_live_cnt  = '0;
        w_kill_cnt  = '0;
        o_match_a   = '0;
        o_match_b   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + PW'(k);
            if (CW'(k) < r_count) begin
                if (r_valid[w_idx]) begin
                    w_live_cnt = w_live_cnt + CW'(1);
                    if (i_kill_en && (r_addr[w_idx] == i_kill_addr))
                        w_kill_cnt = w_kill_cnt + CW'(1);
                    if (r_addr[w_idx] == i_cmp_addr_a)
                        o_match_a[w_idx] = 1'b1;
                    if (r_addr[w_idx] == i_cmp_addr_b)
                        o_match_b[w_idx] = 1'b1;
                    if (!w_found) begin
                        w_found    = 1'b1;
                        w_head_idx = w_idx;
                    end
                end else if (!w_found) begin
                    w_lead_dead = w_lead_dead + CW'(1);
                end
            end
        end
    end

    assign w_pop_live_cnt = CW'(w_found & i_pop_live);
    assign w_pop_cnt      = w_lead_dead + w_pop_live_cnt;
    assign o_can_push     = (r_count - w_pop_cnt) != CW'(DEPTH);
    assign o_live_after   = w_live_cnt - w_kill_cnt - w_pop_live_cnt;
    assign o_head_live    = w_found;
    assign o_head_addr    = r_addr[w_head_idx];
    assign o_head_data    = r_data[w_head_idx];

    // The push write comes after the kill loop so a same-cycle arrival survives.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill_en && (r_addr[i] == i_kill_addr))
                    r_valid[i] <= 1'b0;
            end
            if (i_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PW'(1);
            end
            r_rd_ptr <= r_rd_ptr + PW'(w_pop_cnt);
            r_count  <= r_count - w_pop_cnt + CW'(i_push);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_addr[r_wr_ptr] <= i_push_addr;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the register-file write port between WB and the mul/div unit
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int  DEPTH    = DEF_DEPTH,
    parameter int  MAX_WAIT = DEF_MAX_WAIT,
    localparam int CW       = $clog2(DEPTH) + 1,
    localparam int AW       = $clog2(MAX_WAIT + 1)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_write_en,
    input  logic [4:0]  i_wb_write_addr,
    input  logic [31:0] i_wb_write_data,
    input  logic        i_md_valid,
    input  logic [4:0]  i_md_write_addr,
    input  logic [31:0] i_md_write_data,
    output logic        o_md_ready,
    input  logic [4:0]  i_addr_1_id,
    input  logic [4:0]  i_addr_2_id,
    output logic        o_pending_raw,
    output logic        o_wb_stall,
    output logic        o_write_en,
    output logic [4:0]  o_write_addr,
    output logic [31:0] o_write_data
);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [AW-1:0]    r_age;
    logic [AW-1:0]    w_age_next;
    grant_t           w_grant;
    logic             w_wb_act;
    logic             w_stall;
    logic             w_pop_live;
    logic             w_bypass;
    logic             w_push;
    logic             w_md_ready;
    logic             w_kill_head;
    logic             w_head_live;
    logic [4:0]       w_head_addr;
    logic [31:0]      w_head_data;
    logic             w_can_push;
    logic [CW-1:0]    w_live_after;
    logic [CW-1:0]    w_live_next;
    logic [DEPTH-1:0] w_match_a;
    logic [DEPTH-1:0] w_match_b;
    logic             w_hit_a;
    logic             w_hit_b;

    assign w_wb_act = i_wb_write_en && (i_wb_write_addr != 5'd0);

    always_comb begin
        w_grant    = GRANT_NONE;
        w_stall    = 1'b0;
        w_pop_live = 1'b0;
        w_bypass   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_wb_act) begin
                    w_grant = GRANT_WB;
                end else if (i_md_valid) begin
                    w_bypass = 1'b1;
                    if (i_md_write_addr != 5'd0)
                        w_grant = GRANT_BYPASS;
                end
            end
            ST_BUFFERED: begin
                if (w_wb_act) begin
                    w_grant = GRANT_WB;
                end else if (w_head_live) begin
                    w_grant    = GRANT_MD;
                    w_pop_live = 1'b1;
                end
            end
            ST_STARVED: begin
                w_stall = 1'b1;
                if (w_head_live) begin
                    w_grant    = GRANT_MD;
                    w_pop_live = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_kill_head = (w_grant == GRANT_WB) && w_head_live && (w_head_addr == i_wb_write_addr);
    assign w_md_ready  = w_bypass || w_can_push;
    assign w_push      = i_md_valid && w_md_ready && !w_bypass && (i_md_write_addr != 5'd0);
    assign w_live_next = w_live_after + CW'(w_push);

    // Age only advances while a live head loses to WB; reaching the limit forces one stall cycle.
    always_comb begin
        w_state_next = (w_live_next != '0) ? ST_BUFFERED : ST_IDLE;
        w_age_next   = '0;
        if ((r_state == ST_BUFFERED) && (w_grant == GRANT_WB) && w_head_live && !w_kill_head) begin
            if (r_age >= AW'(MAX_WAIT - 1))
                w_state_next = ST_STARVED;
            else
                w_age_next = r_age + AW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_age   <= '0;
        end else begin
            r_state <= w_state_next;
            r_age   <= w_age_next;
        end
    end

    rf_write_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (w_push),
        .i_push_addr  (i_md_write_addr),
        .i_push_data  (i_md_write_data),
        .i_pop_live   (w_pop_live),
        .i_kill_en    (w_grant == GRANT_WB),
        .i_kill_addr  (i_wb_write_addr),
        .i_cmp_addr_a (i_addr_1_id),
        .i_cmp_addr_b (i_addr_2_id),
        .o_head_live  (w_head_live),
        .o_head_addr  (w_head_addr),
        .o_head_data  (w_head_data),
        .o_can_push   (w_can_push),
        .o_live_after (w_live_after),
        .o_match_a    (w_match_a),
        .o_match_b    (w_match_b)
    );

    assign w_hit_a = (i_addr_1_id != 5'd0) &&
                     ((|w_match_a) || (i_md_valid && (i_md_write_addr == i_addr_1_id)));
    assign w_hit_b = (i_addr_2_id != 5'd0) &&
                     ((|w_match_b) || (i_md_valid && (i_md_write_addr == i_addr_2_id)));

    always_comb begin
        o_write_en   = 1'b0;
        o_write_addr = 5'd0;
        o_write_data = 32'd0;
        case (w_grant)
            GRANT_WB: begin
                o_write_en   = 1'b1;
                o_write_addr = i_wb_write_addr;
                o_write_data = i_wb_write_data;
            end
            GRANT_MD: begin
                o_write_en   = 1'b1;
                o_write_addr = w_head_addr;
                o_write_data = w_head_data;
            end
            GRANT_BYPASS: begin
                o_write_en   = 1'b1;
                o_write_addr = i_md_write_addr;
                o_write_data = i_md_write_data;
            end
            default: ;
        endcase
        if (i_rst) begin
            o_write_en   = 1'b0;
            o_write_addr = 5'd0;
            o_write_data = 32'd0;
        end
    end

    assign o_md_ready    = !i_rst && w_md_ready;
    assign o_wb_stall    = !i_rst && w_stall;
    assign o_pending_raw = !i_rst && (w_hit_a || w_hit_b);

endmodule
